// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_pkg
// Brief   : AES datapath widths and forward S-box table.
// Revision: 1.0
// ============================================================================
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int NUM_BYTES   = 16;

  // Shared with key-expansion SubWord; index with the input byte.
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage : aes_pkg
`default_nettype wire

// File: rtl/sbox_all_if.sv
`default_nettype none
// ============================================================================
// Module  : sbox_all_if
// Brief   : 128-bit state bus into and out of the SubBytes stage.
// Revision: 1.0
// ============================================================================
interface sbox_all_if;
  import aes_pkg::*;

  logic [AES_STATE_W-1:0] Indata;
  logic [AES_STATE_W-1:0] data;

  modport master (output Indata, input data);
  modport slave  (input Indata, output data);

endinterface : sbox_all_if
`default_nettype wire

// File: rtl/aes_sbox_byte.sv
`default_nettype none
// ============================================================================
// Module  : aes_sbox_byte
// Brief   : Combinational forward S-box for a single byte.
// Revision: 1.0
// ============================================================================
module aes_sbox_byte
  import aes_pkg::*;
(
  input  wire logic [AES_BYTE_W-1:0] i_byte,
  output logic      [AES_BYTE_W-1:0] o_byte
);

  assign o_byte = SBOX[i_byte];

endmodule : aes_sbox_byte
`default_nettype wire

// File: rtl/sbox_all.sv
`default_nettype none
// ============================================================================
// Module  : sbox_all
// Brief   : Registered AES SubBytes over the full 128-bit state.
// Revision: 1.0
// ============================================================================
module sbox_all
  import aes_pkg::*;
(
  input  wire logic sc,
  input  wire logic rst,
  sbox_all_if.slave bus
);

  logic [AES_STATE_W-1:0] w_sub;
  logic [AES_STATE_W-1:0] r_data;

  // Lanes are fully independent: byte i in maps to byte i out.
  generate
    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
      aes_sbox_byte u_sbox_byte (
        .i_byte (bus.Indata[AES_BYTE_W*i +: AES_BYTE_W]),
        .o_byte (w_sub[AES_BYTE_W*i +: AES_BYTE_W])
      );
    end
  endgenerate

  always_ff @(posedge sc or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else begin
      r_data <= w_sub;
    end
  end

  assign bus.data = r_data;

endmodule : sbox_all
`default_nettype wire

// File: tb/tb_sbox_all.sv
`default_nettype none
// ============================================================================
// Module  : tb_sbox_all
// Brief   : Self-checking bench for sbox_all against a GF(2^8) S-box model.
// Revision: 1.0
// ============================================================================
module tb_sbox_all;

  logic sc;
  logic rst;
  int   checks;
  int   failures;
  bit   chk_en;

  logic [7:0]   ref_tab [0:255];
  logic [127:0] exp_data;

  sbox_all_if bus ();

  sbox_all dut (
    .sc  (sc),
    .rst (rst),
    .bus (bus)
  );

  initial sc = 1'b0;
  always #5 sc = ~sc;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  // Inverse by search, then the FIPS-197 affine map with constant 0x63.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv, s, c;
    inv = 8'h00;
    c   = 8'h63;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
    end
    for (int k = 0; k < 8; k++) begin
      s[k] = inv[k] ^ inv[(k+4)%8] ^ inv[(k+5)%8] ^ inv[(k+6)%8] ^ inv[(k+7)%8] ^ c[k];
    end
    return s;
  endfunction

  function automatic logic [127:0] sub_state(input logic [127:0] v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = ref_tab[v[8*k +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s t=%0t got=%032h expected=%032h", name, $time, act, expv);
    end
  endtask

  // Reference pipeline: one-cycle delayed substitution, cleared by reset.
  always @(posedge sc or posedge rst) begin
    if (rst) exp_data = '0;
    else     exp_data = sub_state(bus.Indata);
  end

  always @(negedge sc) begin
    if (chk_en) check("pipe", bus.data, exp_data);
  end

  task automatic apply_and_check(input string name, input logic [127:0] v, input logic [127:0] lit);
    bus.Indata = v;
    @(posedge sc); #1;
    check(name, bus.data, lit);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    rst      = 1'b0;
    bus.Indata = '0;
    for (int k = 0; k < 256; k++) ref_tab[k] = sbox_calc(8'(k));

    check("model_s00", {120'h0, ref_tab[8'h00]}, {120'h0, 8'h63});
    check("model_s01", {120'h0, ref_tab[8'h01]}, {120'h0, 8'h7c});
    check("model_s10", {120'h0, ref_tab[8'h10]}, {120'h0, 8'hca});
    check("model_s53", {120'h0, ref_tab[8'h53]}, {120'h0, 8'hed});
    check("model_sff", {120'h0, ref_tab[8'hff]}, {120'h0, 8'h16});

    #1 rst = 1'b1;
    #1 check("reset_state", bus.data, 128'h0);
    chk_en = 1'b1;
    @(posedge sc); #1;
    rst = 1'b0;

    apply_and_check("zero_in", 128'h0, {16{8'h63}});
    apply_and_check("ones_in", {16{8'hff}}, {16{8'h16}});
    // Back-to-back vectors: each result lands exactly one edge after its input.
    apply_and_check("fips_in", 128'h3243f6a8885a308d313198a2e0370734, 128'h231a42c2c4be045dc7c7463ae19ac518);
    apply_and_check("fips_r1", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230);

    // Asynchronous clear between edges with nonzero data held.
    #1 rst = 1'b1;
    #1 check("async_rst", bus.data, 128'h0);
    repeat (3) begin
      @(posedge sc); #1;
      check("rst_hold", bus.data, 128'h0);
    end
    bus.Indata = 128'h3243f6a8885a308d313198a2e0370734;
    rst = 1'b0;
    @(posedge sc); #1;
    check("post_rst", bus.data, 128'h231a42c2c4be045dc7c7463ae19ac518);

    for (int lane = 0; lane < 16; lane++) begin
      for (int v = 0; v < 256; v++) begin
        bus.Indata = 128'(v) << (8*lane);
        @(posedge sc); #1;
      end
    end

    for (int n = 0; n < 600; n++) begin
      bus.Indata = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 31) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      @(posedge sc); #1;
    end

    @(negedge sc); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sbox_all
`default_nettype wire
